queue_sched: RTL

Sequencer and arbiter for the 8-bit, 8-slot circular queue (7 usable entries; full when write pointer + 1 equals read pointer). Two producers share the queue's single write port under round-robin arbitration. A read sequencer drains the queue into a registered valid/ready output stage. An occupancy counter cross-checks the queue's empty/full flags. The block sits between the producers and the queue instance and is the only agent driving the queue's `wr`/`rd`.

---
 rtl/queue_sched.sv | 104 ++++++++++
 1 files changed

// File: rtl/queue_sched.sv
// queue_sched: write arbiter and read sequencer for an 8-slot circular queue
// (QDEPTH usable entries).
//
// Two producers share the queue's single write port under round-robin
// arbitration. Popped entries go into a registered valid/ready output stage.
// An occupancy counter cross-checks the queue's empty/full flags and sets a
// sticky error flag on any disagreement.
//
// Ports:
//   clk, reset            single clock; synchronous active-high reset
//   req0/din0/gnt0        producer 0 request, data, same-cycle grant
//   req1/din1/gnt1        producer 1 request, data, same-cycle grant
//   q_wr/q_din            queue write strobe and write data
//   q_rd                  queue read strobe
//   q_dout                queue head entry (combinational read)
//   q_empty/q_full        queue status flags
//   out_valid/out_data    registered output stage
//   out_ready             consumer accepts out_data at this edge
//   count                 entries held in the queue, not counting the output register
//   err                   sticky flag-consistency error
module queue_sched #(
  parameter int QDEPTH = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] din0,
  output logic       gnt0,
  input  logic       req1,
  input  logic [7:0] din1,
  output logic       gnt1,
  output logic       q_wr,
  output logic [7:0] q_din,
  output logic       q_rd,
  input  logic [7:0] q_dout,
  input  logic       q_empty,
  input  logic       q_full,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic [2:0] count,
  output logic       err
);

  localparam logic [2:0] CNT_MAX = 3'(QDEPTH);

  // Index of the producer granted most recently. A value of 1 means
  // producer 0 wins the next contention.
  logic last;

  // Grants are gated only by q_full. A pop in the same cycle does not free
  // a slot for a grant until the next cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!q_full && !reset) begin
      if (req0 && req1) begin
        gnt0 = last;
        gnt1 = !last;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign q_wr  = gnt0 | gnt1;
  assign q_din = gnt1 ? din1 : din0;

  // Pop whenever the output register is free or is being emptied this edge.
  // A write into an empty queue is never bypassed to the output.
  assign q_rd = !q_empty && (!out_valid || out_ready) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      last      <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      count     <= 3'd0;
      err       <= 1'b0;
    end else begin
      if (q_wr)
        last <= gnt1;

      if (q_rd) begin
        out_data  <= q_dout;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // A simultaneous write and pop leave the occupancy unchanged.
      case ({q_wr, q_rd})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase

      if (((count == 3'd0) != q_empty) || ((count == CNT_MAX) != q_full))
        err <= 1'b1;
    end
  end

endmodule
